vppm_encoder: RTL and testbench

VPPM (variable pulse position modulation) line encoder that sits directly downstream of the ROM-driven PWM/dimming controller. It takes the controller's symbol period and duty (dimming level) plus 12-bit data words, and produces the LED drive waveform. Bit 0 is a pulse at the start of the symbol and bit 1 a pulse at the end, with pulse width = duty. The dimming level is held constant during idle by emitting filler symbols.

---
 rtl/vppm_pkg.sv | 23 ++
 rtl/vppm_symbol_timer.sv | 57 +++++
 rtl/vppm_encoder.sv | 133 +++++++++++++
 tb/tb_vppm_encoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vppm_pkg.sv
// Shared widths, state encoding and the pulse-position rule for the VPPM encoder.
package vppm_pkg;

  localparam int unsigned PeriodW   = 26;  // period / duty / symbol counter width
  localparam int unsigned DataW     = 12;  // data word width
  localparam int unsigned PeriodMin = 2;   // shortest legal symbol, in clk cycles
  localparam int unsigned BitsW     = $clog2(DataW + 1);

  typedef enum logic [0:0] {
    StIdle = 1'b0,  // filler symbols keep the dimming level
    StSend = 1'b1   // data symbols
  } vppm_state_e;

  // Bit 0 pulses at the start of the symbol, bit 1 at the end; both are high for d cycles.
  // d <= p is guaranteed by the caller, so p - d cannot underflow.
  function automatic logic pulse_level(input logic               sym_bit,
                                       input logic [PeriodW-1:0] cnt,
                                       input logic [PeriodW-1:0] p,
                                       input logic [PeriodW-1:0] d);
    return sym_bit ? (cnt >= (p - d)) : (cnt < d);
  endfunction

endpackage

// File: rtl/vppm_symbol_timer.sv
// Free-running symbol counter with per-symbol period/duty capture.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   period_i, duty_i  : requested symbol length / pulse width, sampled at cnt 0
//   cnt_o             : position within the current symbol
//   sym_p_o, sym_d_o  : clamped period/duty in force for the current symbol
//   sym_end_o         : combinational, high on the last cycle of the symbol
//   sym_tick_o        : sym_end_o registered (aligned with the registered LED output)
module vppm_symbol_timer
  import vppm_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PeriodW-1:0] period_i,
  input  logic [PeriodW-1:0] duty_i,
  output logic [PeriodW-1:0] cnt_o,
  output logic [PeriodW-1:0] sym_p_o,
  output logic [PeriodW-1:0] sym_d_o,
  output logic               sym_end_o,
  output logic               sym_tick_o
);

  logic [PeriodW-1:0] cnt_q, cnt_d;
  logic [PeriodW-1:0] p_q, d_q;
  logic [PeriodW-1:0] p_clamp, d_clamp;
  logic               sym_tick_q;

  always_comb begin
    p_clamp = (period_i < PeriodW'(PeriodMin)) ? PeriodW'(PeriodMin) : period_i;
    d_clamp = (duty_i > p_clamp) ? p_clamp : duty_i;
    // On the first cycle of a symbol the captured values are not yet in the
    // registers, so the live clamped inputs stand in for them.
    sym_p_o   = (cnt_q == '0) ? p_clamp : p_q;
    sym_d_o   = (cnt_q == '0) ? d_clamp : d_q;
    sym_end_o = (cnt_q == (sym_p_o - PeriodW'(1)));
    cnt_d     = sym_end_o ? '0 : (cnt_q + PeriodW'(1));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      p_q        <= PeriodW'(PeriodMin);
      d_q        <= '0;
      sym_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sym_tick_q <= sym_end_o;
      if (cnt_q == '0) begin
        p_q <= p_clamp;
        d_q <= d_clamp;
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign sym_tick_o = sym_tick_q;

endmodule

// File: rtl/vppm_encoder.sv
// VPPM line encoder: one-word holding register, MSB-first shifter and the
// pulse-position output rule. Filler (bit 0) symbols are sent while idle so the
// average LED duty stays at D/P.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   period_i, duty_i         : symbol length / pulse width in clk cycles
//   data_in_i, data_valid_i  : word to send; transfer when data_ready_o is also high
//   data_ready_o             : holding register empty
//   vppm_out_o               : registered LED drive
//   sym_tick_o, word_done_o  : one-cycle pulses on the last output cycle of a symbol / word
//   busy_o                   : data (not filler) symbols on the output
module vppm_encoder
  import vppm_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PeriodW-1:0] period_i,
  input  logic [PeriodW-1:0] duty_i,
  input  logic [DataW-1:0]   data_in_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  output logic               vppm_out_o,
  output logic               sym_tick_o,
  output logic               word_done_o,
  output logic               busy_o
);

  logic [PeriodW-1:0] cnt, sym_p, sym_d;
  logic               sym_end;

  vppm_symbol_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .period_i   (period_i),
    .duty_i     (duty_i),
    .cnt_o      (cnt),
    .sym_p_o    (sym_p),
    .sym_d_o    (sym_d),
    .sym_end_o  (sym_end),
    .sym_tick_o (sym_tick_o)
  );

  vppm_state_e        state_q, state_d;
  logic [DataW-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [DataW-1:0]   shift_q, shift_d;
  logic [BitsW-1:0]   bits_left_q, bits_left_d;
  logic               ready_q, vppm_q, done_q, busy_q;
  logic               accept, word_end, sym_bit, vppm_d;

  // ready_q tracks !hold_full one cycle behind the reset release, which keeps
  // the handshake closed on the first cycle out of reset.
  assign accept = data_valid_i && ready_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    word_end    = 1'b0;

    if (sym_end) begin
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) begin
            state_d     = StSend;
            shift_d     = hold_q;
            bits_left_d = BitsW'(DataW);
            hold_full_d = 1'b0;
          end
        end
        StSend: begin
          if (bits_left_q > BitsW'(1)) begin
            shift_d     = {shift_q[DataW-2:0], 1'b0};
            bits_left_d = bits_left_q - BitsW'(1);
          end else begin
            word_end = 1'b1;
            if (hold_full_q) begin
              // Back-to-back word: no filler symbol in between.
              shift_d     = hold_q;
              bits_left_d = BitsW'(DataW);
              hold_full_d = 1'b0;
            end else begin
              state_d     = StIdle;
              bits_left_d = '0;
            end
          end
        end
        default: ;
      endcase
    end

    // Cannot collide with the hold->shifter move: accept needs hold empty.
    if (accept) begin
      hold_d      = data_in_i;
      hold_full_d = 1'b1;
    end
  end

  assign sym_bit = (state_q == StSend) && shift_q[DataW-1];
  assign vppm_d  = pulse_level(sym_bit, cnt, sym_p, sym_d);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bits_left_q <= '0;
      ready_q     <= 1'b0;
      vppm_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      ready_q     <= !hold_full_d;
      vppm_q      <= vppm_d;
      done_q      <= word_end;
      // Registered alongside vppm_q so busy lines up with the symbols on the wire.
      busy_q      <= (state_q == StSend);
    end
  end

  assign data_ready_o = ready_q;
  assign vppm_out_o   = vppm_q;
  assign word_done_o  = done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_vppm_encoder.sv
// Bench for vppm_encoder: symbol-level reference model (bit queue + one pending
// word) compared every cycle, with directed phases followed by random traffic.
module tb_vppm_encoder;
  import vppm_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PeriodW-1:0] period, duty;
  logic [DataW-1:0]   data;
  logic               valid;
  logic               data_ready, vppm_out, sym_tick, word_done, busy;

  always #5 clk = ~clk;

  vppm_encoder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .period_i     (period),
    .duty_i       (duty),
    .data_in_i    (data),
    .data_valid_i (valid),
    .data_ready_o (data_ready),
    .vppm_out_o   (vppm_out),
    .sym_tick_o   (sym_tick),
    .word_done_o  (word_done),
    .busy_o       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int             pos, sym_p, sym_d;
  bit             cur_bit, cur_busy, pend_v, first_m, accepted;
  logic [DataW-1:0] pend_w;
  bit             bits_q[$];

  // Observations for word-length checks
  int   busy_rise = 0, done_cyc = 0, done_cnt = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pos      = 0;
    bits_q.delete();
    pend_v   = 1'b0;
    first_m  = 1'b1;
    cur_bit  = 1'b0;
    cur_busy = 1'b0;
  endtask

  // One clock cycle: inputs are already driven for this cycle.
  task automatic step();
    bit e_v, e_t, e_d, e_b, e_r;
    e_r = !pend_v && !first_m;
    accepted = 1'b0;
    chk("data_ready", data_ready, e_r);
    e_v = 1'b0; e_t = 1'b0; e_d = 1'b0; e_b = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pos == 0) begin
        sym_p    = (int'(period) < 2) ? 2 : int'(period);
        sym_d    = (int'(duty) > sym_p) ? sym_p : int'(duty);
        cur_busy = (bits_q.size() != 0);
        cur_bit  = cur_busy ? bits_q[0] : 1'b0;
      end
      e_v = cur_bit ? (pos >= sym_p - sym_d) : (pos < sym_d);
      e_t = (pos == sym_p - 1);
      e_b = cur_busy;
      if (e_t) begin
        if (cur_busy) begin
          void'(bits_q.pop_front());
          e_d = (bits_q.size() == 0);
        end
        // A word accepted during this very cycle is not yet eligible.
        if (bits_q.size() == 0 && pend_v) begin
          for (int i = DataW - 1; i >= 0; i--) bits_q.push_back(pend_w[i]);
          pend_v = 1'b0;
        end
        pos = 0;
      end else begin
        pos++;
      end
      if (valid && e_r) begin
        pend_v   = 1'b1;
        pend_w   = data;
        accepted = 1'b1;
      end
      first_m = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("vppm_out", vppm_out, e_v);
    chk("sym_tick", sym_tick, e_t);
    chk("word_done", word_done, e_d);
    chk("busy", busy, e_b);
    if (busy && !prev_busy) busy_rise = cyc;
    if (word_done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    prev_busy = busy;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Holds valid high until the model accepts the word (bounded).
  task automatic send(input logic [DataW-1:0] w);
    int n = 0;
    data  = w;
    valid = 1'b1;
    do begin
      step();
      n++;
    end while (!accepted && n < 2000);
    valid = 1'b0;
    if (!accepted) chk("accept_timeout", accepted, 1);
  endtask

  initial begin
    int d0;
    rst_n  = 1'b0;
    period = PeriodW'(10);
    duty   = PeriodW'(3);
    data   = '0;
    valid  = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held, then filler with P=10, D=3
    run(3);
    rst_n = 1'b1;
    run(40);

    // Single word 0xA5A
    d0 = done_cnt;
    send(12'hA5A);
    run(140);
    chk("a5a_done_count", done_cnt - d0, 1);
    chk("a5a_word_cycles", done_cyc - busy_rise + 1, 120);

    // Two words back to back with valid held high
    d0 = done_cnt;
    send(12'hFFF);
    send(12'h000);
    run(260);
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_busy_cycles", done_cyc - busy_rise + 1, 240);

    // Duty extremes: 0, P, above P
    duty = PeriodW'(0);
    send(12'h5C3);
    run(130);
    duty = PeriodW'(10);
    send(12'h3A5);
    run(130);
    duty = PeriodW'(15);
    send(12'hC0F);
    run(130);
    duty = PeriodW'(3);

    // Period change mid-symbol, then period below the minimum
    run(3);
    period = PeriodW'(6);
    run(40);
    period = PeriodW'(1);
    send(12'h9E1);
    run(40);
    period = PeriodW'(10);
    run(30);

    // Reset mid-word with a word still held
    send(12'h6B2);
    send(12'h1D4);
    run(20);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(40);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) period = PeriodW'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) duty = PeriodW'($urandom_range(0, 11));
      valid = ($urandom_range(0, 3) != 0);
      data  = DataW'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1;
    valid = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
